// File: rtl/multicycle_control_pkg.sv
// Shared codes for the multicycle MIPS controller: opcodes, functs, ALU commands,
// FSM state encoding and datapath mux encodings.
package multicycle_control_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_XOR  = 3'd2,
        ALU_SLT  = 3'd3,
        ALU_AND  = 3'd4,
        ALU_NAND = 3'd5,
        ALU_NOR  = 3'd6,
        ALU_OR   = 3'd7
    } alu_cmd_e;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd7
    } state_e;

    localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
    localparam logic [1:0] PC_SRC_REG    = 2'd3;

    localparam logic [1:0] REG_DST_RD  = 2'd0;
    localparam logic [1:0] REG_DST_R31 = 2'd1;
    localparam logic [1:0] REG_DST_RT  = 2'd2;

    localparam logic [1:0] M2R_ALU = 2'd0;
    localparam logic [1:0] M2R_MDR = 2'd1;
    localparam logic [1:0] M2R_PC4 = 2'd2;

    typedef struct packed {
        logic alu_r;
        logic alu_i;
        logic load;
        logic store;
        logic branch;
        logic jump;
        logic jal;
        logic jr;
    } instr_class_t;

    // Jumps and anything without an explicit ALU need default to ADD
    function automatic alu_cmd_e alu_cmd(input logic [5:0] opcode, input logic [5:0] funct);
        alu_cmd_e cmd;
        cmd = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_SUB:  cmd = ALU_SUB;
                    FN_SLT:  cmd = ALU_SLT;
                    default: cmd = ALU_ADD;
                endcase
            end
            OP_BEQ, OP_BNE: cmd = ALU_SUB;
            OP_XORI:        cmd = ALU_XOR;
            default:        cmd = ALU_ADD;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle controller (master) and the datapath (slave).
interface multicycle_control_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             mem_ready;

    logic             ir_wr_en;
    logic             ab_wr_en;
    logic             aluout_wr_en;
    logic             mdr_wr_en;
    logic             pc_wr_en;
    logic [1:0]       pc_src;
    logic             alu_src;
    logic [2:0]       alu_cntrl;
    logic             mem_wr;
    logic             reg_wr;
    logic [1:0]       reg_dst;
    logic [1:0]       mem_to_reg;

    logic [2:0]       state;
    logic             instr_done;
    logic             illegal;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output ir_wr_en, ab_wr_en, aluout_wr_en, mdr_wr_en, pc_wr_en, pc_src,
               alu_src, alu_cntrl, mem_wr, reg_wr, reg_dst, mem_to_reg,
               state, instr_done, illegal, instr_count
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  ir_wr_en, ab_wr_en, aluout_wr_en, mdr_wr_en, pc_wr_en, pc_src,
               alu_src, alu_cntrl, mem_wr, reg_wr, reg_dst, mem_to_reg,
               state, instr_done, illegal, instr_count
    );

endinterface

// File: rtl/multicycle_control_instr_class_decode.sv
// Combinational opcode/funct classifier: one-hot instruction class plus an unsupported flag.
module instr_class_decode
    import multicycle_control_pkg::*;
(
    input  logic [5:0]   i_opcode,
    input  logic [5:0]   i_funct,
    output instr_class_t o_class,
    output logic         o_illegal
);

    always_comb begin
        o_class   = '0;
        o_illegal = 1'b0;
        case (i_opcode)
            OP_RTYPE: begin
                case (i_funct)
                    FN_ADD, FN_SUB, FN_SLT: o_class.alu_r = 1'b1;
                    FN_JR:                  o_class.jr    = 1'b1;
                    default:                o_illegal     = 1'b1;
                endcase
            end
            OP_J:            o_class.jump   = 1'b1;
            OP_JAL:          o_class.jal    = 1'b1;
            OP_BEQ, OP_BNE:  o_class.branch = 1'b1;
            OP_ADDI, OP_XORI: o_class.alu_i = 1'b1;
            OP_LW:           o_class.load   = 1'b1;
            OP_SW:           o_class.store  = 1'b1;
            default:         o_illegal      = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS sequencing FSM: drives datapath latch enables, mux selects and
// write strobes per cycle, and counts retired instructions.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter bit USE_RDY = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.master io_ctrl
);

    state_e           r_state;
    state_e           w_next;
    logic             r_illegal;
    logic [CNT_W-1:0] r_count;

    instr_class_t     w_class;
    logic             w_unsupported;
    logic             w_rdy;
    logic             w_take_branch;
    logic             w_retire;

    logic             w_ir_wr_en;
    logic             w_ab_wr_en;
    logic             w_aluout_wr_en;
    logic             w_mdr_wr_en;
    logic [1:0]       w_pc_src;
    logic             w_alu_src;
    alu_cmd_e         w_alu_cntrl;
    logic             w_mem_wr;
    logic             w_reg_wr;
    logic [1:0]       w_reg_dst;
    logic [1:0]       w_mem_to_reg;

    instr_class_decode u_decode (
        .i_opcode  (io_ctrl.opcode),
        .i_funct   (io_ctrl.funct),
        .o_class   (w_class),
        .o_illegal (w_unsupported)
    );

    assign w_rdy         = USE_RDY ? io_ctrl.mem_ready : 1'b1;
    assign w_take_branch = ((io_ctrl.opcode == OP_BEQ) &&  io_ctrl.zero) ||
                           ((io_ctrl.opcode == OP_BNE) && !io_ctrl.zero);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count   <= '0;
            r_illegal <= 1'b0;
        end else begin
            if (w_retire) begin
                r_count <= r_count + 1'b1;
            end
            if (w_next == ST_TRAP) begin
                r_illegal <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next         = r_state;
        w_retire       = 1'b0;
        w_ir_wr_en     = 1'b0;
        w_ab_wr_en     = 1'b0;
        w_aluout_wr_en = 1'b0;
        w_mdr_wr_en    = 1'b0;
        w_pc_src       = PC_SRC_SEQ;
        w_alu_src      = 1'b0;
        w_alu_cntrl    = ALU_ADD;
        w_mem_wr       = 1'b0;
        w_reg_wr       = 1'b0;
        w_reg_dst      = REG_DST_RD;
        w_mem_to_reg   = M2R_ALU;

        case (r_state)
            ST_FETCH: begin
                w_ir_wr_en = w_rdy;
                if (w_rdy) begin
                    w_next = ST_DECODE;
                end
            end

            ST_DECODE: begin
                w_ab_wr_en = 1'b1;
                w_next     = w_unsupported ? ST_TRAP : ST_EXEC;
            end

            // Control transfers retire here; everything else moves on to MEM or WB
            ST_EXEC: begin
                w_aluout_wr_en = 1'b1;
                w_alu_cntrl    = alu_cmd(io_ctrl.opcode, io_ctrl.funct);
                w_alu_src      = w_class.alu_i | w_class.load | w_class.store;
                if (w_class.branch) begin
                    w_retire = 1'b1;
                    w_pc_src = w_take_branch ? PC_SRC_BRANCH : PC_SRC_SEQ;
                end else if (w_class.jump) begin
                    w_retire = 1'b1;
                    w_pc_src = PC_SRC_JUMP;
                end else if (w_class.jr) begin
                    w_retire = 1'b1;
                    w_pc_src = PC_SRC_REG;
                end else if (w_class.jal) begin
                    w_retire     = 1'b1;
                    w_pc_src     = PC_SRC_JUMP;
                    w_reg_wr     = 1'b1;
                    w_reg_dst    = REG_DST_R31;
                    w_mem_to_reg = M2R_PC4;
                end else if (w_class.load || w_class.store) begin
                    w_next = ST_MEM;
                end else begin
                    w_next = ST_WB;
                end
            end

            ST_MEM: begin
                if (w_class.load) begin
                    w_mdr_wr_en = w_rdy;
                    if (w_rdy) begin
                        w_next = ST_WB;
                    end
                end else begin
                    w_mem_wr = 1'b1;
                    w_retire = w_rdy;
                end
            end

            ST_WB: begin
                w_reg_wr     = 1'b1;
                w_reg_dst    = w_class.alu_r ? REG_DST_RD : REG_DST_RT;
                w_mem_to_reg = w_class.load ? M2R_MDR : M2R_ALU;
                w_retire     = 1'b1;
            end

            ST_TRAP: begin
                w_next = ST_TRAP;
            end

            default: begin
                w_next = ST_FETCH;
            end
        endcase

        if (w_retire) begin
            w_next = ST_FETCH;
        end

        // Reset kills every strobe combinationally so an in-flight store cannot complete
        if (!rst_n) begin
            w_retire       = 1'b0;
            w_ir_wr_en     = 1'b0;
            w_ab_wr_en     = 1'b0;
            w_aluout_wr_en = 1'b0;
            w_mdr_wr_en    = 1'b0;
            w_pc_src       = PC_SRC_SEQ;
            w_alu_src      = 1'b0;
            w_alu_cntrl    = ALU_ADD;
            w_mem_wr       = 1'b0;
            w_reg_wr       = 1'b0;
            w_reg_dst      = REG_DST_RD;
            w_mem_to_reg   = M2R_ALU;
        end
    end

    assign io_ctrl.ir_wr_en     = w_ir_wr_en;
    assign io_ctrl.ab_wr_en     = w_ab_wr_en;
    assign io_ctrl.aluout_wr_en = w_aluout_wr_en;
    assign io_ctrl.mdr_wr_en    = w_mdr_wr_en;
    assign io_ctrl.pc_wr_en     = w_retire;
    assign io_ctrl.pc_src       = w_pc_src;
    assign io_ctrl.alu_src      = w_alu_src;
    assign io_ctrl.alu_cntrl    = w_alu_cntrl;
    assign io_ctrl.mem_wr       = w_mem_wr;
    assign io_ctrl.reg_wr       = w_reg_wr;
    assign io_ctrl.reg_dst      = w_reg_dst;
    assign io_ctrl.mem_to_reg   = w_mem_to_reg;
    assign io_ctrl.state        = r_state;
    assign io_ctrl.instr_done   = w_retire;
    assign io_ctrl.illegal      = r_illegal;
    assign io_ctrl.instr_count  = r_count;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: each stimulus cycle queues a hand-built expected
// control vector, and a negedge monitor pops and compares it against the DUT outputs.
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    localparam int CNT_W = 32;

    typedef struct packed {
        logic [2:0]  state;
        logic        ir;
        logic        ab;
        logic        aluout;
        logic        mdr;
        logic        pcwr;
        logic [1:0]  pcSrc;
        logic        aluSrc;
        logic [2:0]  aluCntrl;
        logic        memWr;
        logic        regWr;
        logic [1:0]  regDst;
        logic [1:0]  memToReg;
        logic        done;
        logic        illegal;
        logic [31:0] count;
    } ctrlVec_t;

    typedef struct {
        ctrlVec_t v;
        string    name;
    } expEntry_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    expEntry_t   expQ[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] expCount = '0;

    multicycle_control_if #(.CNT_W(CNT_W)) bus ();

    multicycle_control #(.CNT_W(CNT_W), .USE_RDY(1'b1)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .io_ctrl (bus)
    );

    always #5 clk = ~clk;

    function automatic ctrlVec_t base(input logic [2:0] st);
        ctrlVec_t v;
        v = '0;
        v.state = st;
        return v;
    endfunction

    function automatic ctrlVec_t vFetch(input logic rdy);
        ctrlVec_t v;
        v = base(3'd0);
        v.ir = rdy;
        return v;
    endfunction

    function automatic ctrlVec_t vDecode();
        ctrlVec_t v;
        v = base(3'd1);
        v.ab = 1'b1;
        return v;
    endfunction

    function automatic ctrlVec_t vExec(input logic [2:0] cntrl, input logic src);
        ctrlVec_t v;
        v = base(3'd2);
        v.aluout = 1'b1;
        v.aluCntrl = cntrl;
        v.aluSrc = src;
        return v;
    endfunction

    function automatic ctrlVec_t vMem(input logic mdr, input logic memWr);
        ctrlVec_t v;
        v = base(3'd3);
        v.mdr = mdr;
        v.memWr = memWr;
        return v;
    endfunction

    function automatic ctrlVec_t vWb(input logic [1:0] regDst, input logic [1:0] memToReg);
        ctrlVec_t v;
        v = base(3'd4);
        v.regWr = 1'b1;
        v.regDst = regDst;
        v.memToReg = memToReg;
        return v;
    endfunction

    function automatic ctrlVec_t retire(input ctrlVec_t vin, input logic [1:0] pcSrc);
        ctrlVec_t v;
        v = vin;
        v.pcwr = 1'b1;
        v.done = 1'b1;
        v.pcSrc = pcSrc;
        return v;
    endfunction

    // Drive one cycle of inputs just after the rising edge and queue what the DUT must show
    task automatic applyStimulus(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                                 input logic z, input logic rdy, input ctrlVec_t e, input string name);
        expEntry_t x;
        @(posedge clk);
        #1;
        rst_n = rst;
        bus.opcode = op;
        bus.funct = fn;
        bus.zero = z;
        bus.mem_ready = rdy;
        if (!rst) expCount = '0;
        x.v = e;
        x.v.count = expCount;
        x.name = name;
        expQ.push_back(x);
        if (e.done) expCount = expCount + 1;
    endtask

    task automatic fetchDecode(input logic [5:0] op, input logic [5:0] fn, input string name);
        applyStimulus(1'b1, op, fn, 1'b0, 1'b1, vFetch(1'b1), {name, ".fetch"});
        applyStimulus(1'b1, op, fn, 1'b0, 1'b1, vDecode(), {name, ".decode"});
    endtask

    task automatic checkOutput(input expEntry_t x);
        ctrlVec_t a;
        a.state = bus.state;
        a.ir = bus.ir_wr_en;
        a.ab = bus.ab_wr_en;
        a.aluout = bus.aluout_wr_en;
        a.mdr = bus.mdr_wr_en;
        a.pcwr = bus.pc_wr_en;
        a.pcSrc = bus.pc_src;
        a.aluSrc = bus.alu_src;
        a.aluCntrl = bus.alu_cntrl;
        a.memWr = bus.mem_wr;
        a.regWr = bus.reg_wr;
        a.regDst = bus.reg_dst;
        a.memToReg = bus.mem_to_reg;
        a.done = bus.instr_done;
        a.illegal = bus.illegal;
        a.count = bus.instr_count;
        checks++;
        if (a !== x.v) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (state got %0d expected %0d)",
                     x.name, a, x.v, a.state, x.v.state);
        end
    endtask

    // Monitor: the DUT presents a full control vector every cycle; compare mid-cycle
    always @(negedge clk) begin
        expEntry_t x;
        if (expQ.size() > 0) begin
            x = expQ.pop_front();
            checkOutput(x);
        end
    end

    initial begin
        ctrlVec_t v;
        bus.opcode = '0;
        bus.funct = '0;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b1;

        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 6'h00, 6'h00, 1'b0, 1'b1, base(3'd0), "reset");

        fetchDecode(OP_ADDI, 6'h00, "addi");
        applyStimulus(1'b1, OP_ADDI, 6'h00, 1'b0, 1'b1, vExec(ALU_ADD, 1'b1), "addi.exec");
        applyStimulus(1'b1, OP_ADDI, 6'h00, 1'b0, 1'b1, retire(vWb(REG_DST_RT, M2R_ALU), PC_SRC_SEQ), "addi.wb");

        fetchDecode(OP_LW, 6'h00, "lw");
        applyStimulus(1'b1, OP_LW, 6'h00, 1'b0, 1'b1, vExec(ALU_ADD, 1'b1), "lw.exec");
        applyStimulus(1'b1, OP_LW, 6'h00, 1'b0, 1'b0, vMem(1'b0, 1'b0), "lw.mem.wait1");
        applyStimulus(1'b1, OP_LW, 6'h00, 1'b0, 1'b0, vMem(1'b0, 1'b0), "lw.mem.wait2");
        applyStimulus(1'b1, OP_LW, 6'h00, 1'b0, 1'b1, vMem(1'b1, 1'b0), "lw.mem.ready");
        applyStimulus(1'b1, OP_LW, 6'h00, 1'b0, 1'b1, retire(vWb(REG_DST_RT, M2R_MDR), PC_SRC_SEQ), "lw.wb");

        applyStimulus(1'b1, OP_BEQ, 6'h00, 1'b0, 1'b0, vFetch(1'b0), "beq.fetch.wait");
        fetchDecode(OP_BEQ, 6'h00, "beq1");
        applyStimulus(1'b1, OP_BEQ, 6'h00, 1'b1, 1'b1, retire(vExec(ALU_SUB, 1'b0), PC_SRC_BRANCH), "beq.taken");
        fetchDecode(OP_BEQ, 6'h00, "beq0");
        applyStimulus(1'b1, OP_BEQ, 6'h00, 1'b0, 1'b1, retire(vExec(ALU_SUB, 1'b0), PC_SRC_SEQ), "beq.nottaken");
        fetchDecode(OP_BNE, 6'h00, "bne1");
        applyStimulus(1'b1, OP_BNE, 6'h00, 1'b1, 1'b1, retire(vExec(ALU_SUB, 1'b0), PC_SRC_SEQ), "bne.nottaken");
        fetchDecode(OP_BNE, 6'h00, "bne0");
        applyStimulus(1'b1, OP_BNE, 6'h00, 1'b0, 1'b1, retire(vExec(ALU_SUB, 1'b0), PC_SRC_BRANCH), "bne.taken");

        fetchDecode(OP_JAL, 6'h00, "jal");
        v = vExec(ALU_ADD, 1'b0);
        v.regWr = 1'b1;
        v.regDst = REG_DST_R31;
        v.memToReg = M2R_PC4;
        applyStimulus(1'b1, OP_JAL, 6'h00, 1'b0, 1'b1, retire(v, PC_SRC_JUMP), "jal.exec");
        fetchDecode(OP_RTYPE, FN_JR, "jr");
        applyStimulus(1'b1, OP_RTYPE, FN_JR, 1'b0, 1'b1, retire(vExec(ALU_ADD, 1'b0), PC_SRC_REG), "jr.exec");
        fetchDecode(OP_J, 6'h00, "j");
        applyStimulus(1'b1, OP_J, 6'h00, 1'b0, 1'b1, retire(vExec(ALU_ADD, 1'b0), PC_SRC_JUMP), "j.exec");

        fetchDecode(OP_RTYPE, FN_SLT, "slt");
        applyStimulus(1'b1, OP_RTYPE, FN_SLT, 1'b0, 1'b1, vExec(ALU_SLT, 1'b0), "slt.exec");
        applyStimulus(1'b1, OP_RTYPE, FN_SLT, 1'b0, 1'b1, retire(vWb(REG_DST_RD, M2R_ALU), PC_SRC_SEQ), "slt.wb");
        fetchDecode(OP_XORI, 6'h00, "xori");
        applyStimulus(1'b1, OP_XORI, 6'h00, 1'b0, 1'b1, vExec(ALU_XOR, 1'b1), "xori.exec");
        applyStimulus(1'b1, OP_XORI, 6'h00, 1'b0, 1'b1, retire(vWb(REG_DST_RT, M2R_ALU), PC_SRC_SEQ), "xori.wb");
        fetchDecode(OP_RTYPE, FN_SUB, "sub");
        applyStimulus(1'b1, OP_RTYPE, FN_SUB, 1'b0, 1'b1, vExec(ALU_SUB, 1'b0), "sub.exec");
        applyStimulus(1'b1, OP_RTYPE, FN_SUB, 1'b0, 1'b1, retire(vWb(REG_DST_RD, M2R_ALU), PC_SRC_SEQ), "sub.wb");

        fetchDecode(OP_SW, 6'h00, "sw");
        applyStimulus(1'b1, OP_SW, 6'h00, 1'b0, 1'b1, vExec(ALU_ADD, 1'b1), "sw.exec");
        applyStimulus(1'b1, OP_SW, 6'h00, 1'b0, 1'b0, vMem(1'b0, 1'b1), "sw.mem.wait");
        applyStimulus(1'b1, OP_SW, 6'h00, 1'b0, 1'b1, retire(vMem(1'b0, 1'b1), PC_SRC_SEQ), "sw.mem.ready");

        fetchDecode(OP_SW, 6'h00, "swrst");
        applyStimulus(1'b1, OP_SW, 6'h00, 1'b0, 1'b1, vExec(ALU_ADD, 1'b1), "swrst.exec");
        applyStimulus(1'b1, OP_SW, 6'h00, 1'b0, 1'b0, vMem(1'b0, 1'b1), "swrst.mem.wait");
        applyStimulus(1'b0, OP_SW, 6'h00, 1'b0, 1'b1, base(3'd0), "swrst.reset.midmem");

        fetchDecode(6'h3F, 6'h00, "illegal");
        v = base(3'd7);
        v.illegal = 1'b1;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 6'h3F, 6'h00, i[0], i[1], v, "trap.hold");
        end

        repeat (2) @(negedge clk);
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
